decode_stage: RTL and testbench

Second pipeline stage of the 17-bit-instruction, 12-bit-PC processor. It consumes the IF/ID outputs (InstrD, PCD, PCPlus4D), decodes the instruction, and reads the 16-entry register file, which is written from writeback. It drives the ID/EX pipeline register and squashes wrong-path instructions when Execute redirects the PC through PCSrcE.

---
 rtl/decode_pkg.sv | 69 ++++++
 rtl/decode_stage_register_file.sv | 41 ++++
 rtl/decode_stage.sv | 192 +++++++++++++++++++
 tb/tb_decode_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg
// Shared definitions for the decode stage of the 17-bit-instruction,
// 12-bit-PC processor: opcode constants, ResultSrc and ALUControl
// encodings, instruction field positions, sign-extension helpers and the
// packed ID/EX pipeline register layout.
package decode_pkg;

    // Datapath width of register operands and extended immediates.
    localparam int ID_DATA_W = 32;

    // Instruction field positions: op=[16:12], A=[11:8], B=[7:4], C=[3:0].
    localparam int OP_HI = 16;
    localparam int OP_LO = 12;
    localparam int FA_HI = 11;
    localparam int FA_LO = 8;
    localparam int FB_HI = 7;
    localparam int FB_LO = 4;
    localparam int FC_HI = 3;
    localparam int FC_LO = 0;

    // Opcode class prefixes (op[4:3]) and full opcodes.
    localparam logic [1:0] CLASS_RTYPE = 2'b00;
    localparam logic [1:0] CLASS_IALU  = 2'b01;
    localparam logic [4:0] OP_LOAD     = 5'b10000;
    localparam logic [4:0] OP_STORE    = 5'b10001;
    localparam logic [4:0] OP_BEQ      = 5'b11000;
    localparam logic [4:0] OP_BNE      = 5'b11001;
    localparam logic [4:0] OP_JAL      = 5'b11100;

    // ResultSrc encodings.
    typedef enum logic [1:0] {
        RES_ALU    = 2'b00,
        RES_MEM    = 2'b01,
        RES_PCPLUS = 2'b10
    } result_src_e;

    // ALUControl encodings used directly by the decoder.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    // ID/EX pipeline register contents.
    typedef struct packed {
        logic                 regWrite;
        logic                 memWrite;
        logic                 aluSrc;
        logic                 branch;
        logic                 branchNe;
        logic                 jump;
        logic [1:0]           resultSrc;
        logic [2:0]           aluControl;
        logic [ID_DATA_W-1:0] rd1;
        logic [ID_DATA_W-1:0] rd2;
        logic [ID_DATA_W-1:0] immExt;
        logic [3:0]           rs1;
        logic [3:0]           rs2;
        logic [3:0]           rd;
        logic [11:0]          pc;
        logic [11:0]          pcPlus4;
    } id_ex_t;

    function automatic logic [ID_DATA_W-1:0] sext4(input logic [3:0] v);
        return {{(ID_DATA_W-4){v[3]}}, v};
    endfunction

    function automatic logic [ID_DATA_W-1:0] sext8(input logic [7:0] v);
        return {{(ID_DATA_W-8){v[7]}}, v};
    endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// register_file
// 16 x DATA_W register file with two combinational read ports and one
// write port that commits on the falling clock edge, so a value written
// during a cycle is visible to the decode reads before the next rising
// edge. Register 0 always reads zero and ignores writes.
// Ports:
//   clk, reset          clock, asynchronous active-low clear
//   raddr1_i/raddr2_i   read indices
//   rdata1_o/rdata2_o   read data
//   we_i/waddr_i/wdata_i write enable, index and data
module register_file #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        raddr1_i,
    input  logic [3:0]        raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o,
    input  logic              we_i,
    input  logic [3:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] regs_q [16];

    // Falling-edge write gives write-then-read behaviour within one cycle.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 4'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == 4'd0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == 4'd0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/decode_stage.sv
// decode_stage
// Decode stage: decodes InstrD, reads the register file and drives the
// ID/EX pipeline register. A taken branch/jump in Execute (PCSrcE)
// squashes the instruction in Decode and the one fetched alongside it by
// loading two bubbles.
// Optional feature macro: LOAD_USE_STALL_EN enables load-use hazard
// detection (StallFD and a stall bubble); otherwise StallFD is tied to 0.
// Source/destination indices a format does not use decode as 0, so their
// register reads and forwarding indices are zero.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   InstrD, PCD, PCPlus4D      IF/ID contents
//   PCSrcE                     flush request from Execute
//   RegWriteW, RdW, ResultW    writeback port
//   *E outputs                 ID/EX pipeline register
//   StallFD                    hold PC and IF/ID on a load-use hazard
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W = ID_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [16:0]       InstrD,
    input  logic [11:0]       PCD,
    input  logic [11:0]       PCPlus4D,
    input  logic              PCSrcE,
    input  logic              RegWriteW,
    input  logic [3:0]        RdW,
    input  logic [DATA_W-1:0] ResultW,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic              ALUSrcE,
    output logic              BranchE,
    output logic              BranchNeE,
    output logic              JumpE,
    output logic [1:0]        ResultSrcE,
    output logic [2:0]        ALUControlE,
    output logic [DATA_W-1:0] RD1E,
    output logic [DATA_W-1:0] RD2E,
    output logic [DATA_W-1:0] ImmExtE,
    output logic [3:0]        Rs1E,
    output logic [3:0]        Rs2E,
    output logic [3:0]        RdE,
    output logic [11:0]       PCE,
    output logic [11:0]       PCPlus4E,
    output logic              StallFD
);

    id_ex_t            idEx_d;
    id_ex_t            idEx_q;
    logic              flush_q;
    logic              stall;
    logic [3:0]        rs1Sel;
    logic [3:0]        rs2Sel;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;

    logic [4:0] op;
    logic [3:0] fA;
    logic [3:0] fB;
    logic [3:0] fC;

    assign op = InstrD[OP_HI:OP_LO];
    assign fA = InstrD[FA_HI:FA_LO];
    assign fB = InstrD[FB_HI:FB_LO];
    assign fC = InstrD[FC_HI:FC_LO];

    register_file #(.DATA_W(DATA_W)) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .raddr1_i (rs1Sel),
        .raddr2_i (rs2Sel),
        .rdata1_o (rdata1),
        .rdata2_o (rdata2),
        .we_i     (RegWriteW),
        .waddr_i  (RdW),
        .wdata_i  (ResultW)
    );

    // Instruction decode into the next ID/EX contents.
    always_comb begin
        idEx_d         = '0;
        idEx_d.pc      = PCD;
        idEx_d.pcPlus4 = PCPlus4D;
        if (op[4:3] == CLASS_RTYPE) begin
            idEx_d.rd         = fA;
            idEx_d.rs1        = fB;
            idEx_d.rs2        = fC;
            idEx_d.aluControl = op[2:0];
            idEx_d.regWrite   = 1'b1;
        end else if (op[4:3] == CLASS_IALU) begin
            idEx_d.rd         = fA;
            idEx_d.rs1        = fB;
            idEx_d.immExt     = sext4(fC);
            idEx_d.aluSrc     = 1'b1;
            idEx_d.regWrite   = 1'b1;
            idEx_d.aluControl = op[2:0];
        end else begin
            case (op)
                OP_LOAD: begin
                    idEx_d.rd         = fA;
                    idEx_d.rs1        = fB;
                    idEx_d.immExt     = sext4(fC);
                    idEx_d.aluSrc     = 1'b1;
                    idEx_d.regWrite   = 1'b1;
                    idEx_d.resultSrc  = RES_MEM;
                    idEx_d.aluControl = ALU_ADD;
                end
                OP_STORE: begin
                    idEx_d.rs2        = fA;
                    idEx_d.rs1        = fB;
                    idEx_d.immExt     = sext4(fC);
                    idEx_d.aluSrc     = 1'b1;
                    idEx_d.memWrite   = 1'b1;
                    idEx_d.aluControl = ALU_ADD;
                end
                OP_BEQ, OP_BNE: begin
                    idEx_d.rs1        = fA;
                    idEx_d.rs2        = fB;
                    idEx_d.immExt     = sext4(fC);
                    idEx_d.branch     = 1'b1;
                    idEx_d.branchNe   = op[0];
                    idEx_d.aluControl = ALU_SUB;
                end
                OP_JAL: begin
                    idEx_d.rd        = fA;
                    idEx_d.immExt    = sext8(InstrD[7:0]);
                    idEx_d.jump      = 1'b1;
                    idEx_d.regWrite  = 1'b1;
                    idEx_d.resultSrc = RES_PCPLUS;
                end
                default: begin
                end
            endcase
        end
        idEx_d.rd1 = rdata1;
        idEx_d.rd2 = rdata2;
    end

    assign rs1Sel = idEx_d.rs1;
    assign rs2Sel = idEx_d.rs2;

`ifdef LOAD_USE_STALL_EN
    // Unused sources decode as r0 and RdE must be nonzero, so an index
    // match alone means the instruction in D really reads the load target.
    assign stall = !PCSrcE
                && (idEx_q.resultSrc == RES_MEM)
                && idEx_q.regWrite
                && (idEx_q.rd != 4'd0)
                && ((idEx_d.rs1 == idEx_q.rd) || (idEx_d.rs2 == idEx_q.rd));
`else
    assign stall = 1'b0;
`endif

    assign StallFD = stall;

    // ID/EX register: flush (current or previous PCSrcE) beats stall beats load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idEx_q  <= '0;
            flush_q <= 1'b0;
        end else begin
            flush_q <= PCSrcE;
            if (PCSrcE || flush_q) begin
                idEx_q <= '0;
            end else if (stall) begin
                idEx_q <= '0;
            end else begin
                idEx_q <= idEx_d;
            end
        end
    end

    assign RegWriteE   = idEx_q.regWrite;
    assign MemWriteE   = idEx_q.memWrite;
    assign ALUSrcE     = idEx_q.aluSrc;
    assign BranchE     = idEx_q.branch;
    assign BranchNeE   = idEx_q.branchNe;
    assign JumpE       = idEx_q.jump;
    assign ResultSrcE  = idEx_q.resultSrc;
    assign ALUControlE = idEx_q.aluControl;
    assign RD1E        = idEx_q.rd1;
    assign RD2E        = idEx_q.rd2;
    assign ImmExtE     = idEx_q.immExt;
    assign Rs1E        = idEx_q.rs1;
    assign Rs2E        = idEx_q.rs2;
    assign RdE         = idEx_q.rd;
    assign PCE         = idEx_q.pc;
    assign PCPlus4E    = idEx_q.pcPlus4;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
// Directed plus randomized bench for decode_stage. A behavioural model
// decodes each instruction by format, keeps the register file as an
// array and tracks the flush window, and every E output is compared
// one rising edge after the instruction is presented.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [16:0] InstrD;
    logic [11:0] PCD;
    logic [11:0] PCPlus4D;
    logic        PCSrcE;
    logic        RegWriteW;
    logic [3:0]  RdW;
    logic [31:0] ResultW;
    logic        RegWriteE, MemWriteE, ALUSrcE, BranchE, BranchNeE, JumpE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE;
    logic [3:0]  Rs1E, Rs2E, RdE;
    logic [11:0] PCE, PCPlus4E;
    logic        StallFD;

    int testCount = 0;
    int failCount = 0;

    typedef struct {
        bit        rw, mw, as, br, bne, j;
        bit [1:0]  rsrc;
        bit [2:0]  alu;
        bit [31:0] rd1, rd2, imm;
        bit [3:0]  s1, s2, d;
        bit [11:0] pc, pc4;
    } exp_t;

    logic [31:0] regsModel [16];
    exp_t        curE;
    bit          flushPrev;
    logic [11:0] pcCnt;

    decode_stage dut (
        .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .PCSrcE(PCSrcE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
        .BranchE(BranchE), .BranchNeE(BranchNeE), .JumpE(JumpE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .StallFD(StallFD)
    );

    always #5 clk = ~clk;

    function automatic exp_t zeroE();
        exp_t e;
        e = '{default: 0};
        return e;
    endfunction

    // Reference decode by instruction format, using integer sign extension.
    function automatic exp_t refDecode(input logic [16:0] ins, input logic [11:0] pc,
                                       input logic [11:0] pc4);
        exp_t e;
        int   opc, a, b, c, lo8, v;
        e   = zeroE();
        opc = int'(ins[16:12]);
        a   = int'(ins[11:8]);
        b   = int'(ins[7:4]);
        c   = int'(ins[3:0]);
        lo8 = int'(ins[7:0]);
        v   = (c >= 8) ? c - 16 : c;
        e.pc  = pc;
        e.pc4 = pc4;
        if (opc < 8) begin
            e.d = 4'(a); e.s1 = 4'(b); e.s2 = 4'(c); e.alu = 3'(opc % 8); e.rw = 1;
        end else if (opc < 16) begin
            e.d = 4'(a); e.s1 = 4'(b); e.imm = 32'(v); e.as = 1; e.rw = 1;
            e.alu = 3'(opc % 8);
        end else if (opc == 16) begin
            e.d = 4'(a); e.s1 = 4'(b); e.imm = 32'(v); e.as = 1; e.rw = 1; e.rsrc = 2'd1;
        end else if (opc == 17) begin
            e.s2 = 4'(a); e.s1 = 4'(b); e.imm = 32'(v); e.as = 1; e.mw = 1;
        end else if (opc == 24 || opc == 25) begin
            e.s1 = 4'(a); e.s2 = 4'(b); e.imm = 32'(v); e.br = 1; e.bne = (opc == 25);
            e.alu = 3'd1;
        end else if (opc == 28) begin
            e.d = 4'(a); e.imm = 32'((lo8 >= 128) ? lo8 - 256 : lo8); e.j = 1; e.rw = 1;
            e.rsrc = 2'd2;
        end
        e.rd1 = (e.s1 == 0) ? 32'd0 : regsModel[e.s1];
        e.rd2 = (e.s2 == 0) ? 32'd0 : regsModel[e.s2];
        return e;
    endfunction

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        testCount++;
        assert (obs === expv) else begin
            failCount++;
            $error("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic checkOutput(input string tag, input exp_t e);
        checkVal({tag, "_ctrl"},
                 64'({RegWriteE, MemWriteE, ALUSrcE, BranchE, BranchNeE, JumpE, ResultSrcE, ALUControlE}),
                 64'({e.rw, e.mw, e.as, e.br, e.bne, e.j, e.rsrc, e.alu}));
        checkVal({tag, "_rd1"}, 64'(RD1E), 64'(e.rd1));
        checkVal({tag, "_rd2"}, 64'(RD2E), 64'(e.rd2));
        checkVal({tag, "_imm"}, 64'(ImmExtE), 64'(e.imm));
        checkVal({tag, "_idx"}, 64'({Rs1E, Rs2E, RdE}), 64'({e.s1, e.s2, e.d}));
        checkVal({tag, "_pc"}, 64'({PCE, PCPlus4E}), 64'({e.pc, e.pc4}));
    endtask

    // Present one instruction (plus writeback) for one cycle and check E.
    task automatic applyStimulus(input string tag, input logic [16:0] ins, input bit pcsrc,
                                 input bit we, input logic [3:0] wrd, input logic [31:0] wdata);
        exp_t dec, nextE;
        bit   stallExp;
        InstrD    = ins;
        PCD       = pcCnt;
        PCPlus4D  = pcCnt + 12'd1;
        PCSrcE    = pcsrc;
        RegWriteW = we;
        RdW       = wrd;
        ResultW   = wdata;
        if (we && wrd != 4'd0) regsModel[wrd] = wdata;
        dec      = refDecode(ins, PCD, PCPlus4D);
        stallExp = 0;
`ifdef LOAD_USE_STALL_EN
        stallExp = !pcsrc && curE.rsrc == 2'd1 && curE.rw && curE.d != 0
                   && ((dec.s1 == curE.d) || (dec.s2 == curE.d));
`endif
        #1;
        checkVal({tag, "_stall"}, 64'(StallFD), 64'(stallExp));
        nextE     = (pcsrc || flushPrev || stallExp) ? zeroE() : dec;
        flushPrev = pcsrc;
        curE      = nextE;
        @(posedge clk);
        #1;
        checkOutput(tag, curE);
        pcCnt = pcCnt + 12'd1;
    endtask

    initial begin
        reset     = 1'b0;
        InstrD    = 17'($urandom);
        PCD       = 12'h0AB;
        PCPlus4D  = 12'h0AC;
        PCSrcE    = 1'b1;
        RegWriteW = 1'b1;
        RdW       = 4'd7;
        ResultW   = 32'hFFFF_FFFF;
        for (int i = 0; i < 16; i++) regsModel[i] = 32'd0;
        curE      = zeroE();
        flushPrev = 0;
        pcCnt     = 12'h100;

        // Reset held with random inputs, including a pending flush request.
        #2;
        checkOutput("reset0", zeroE());
        checkVal("reset0_stall", 64'(StallFD), 64'd0);
        @(posedge clk); #1;
        InstrD = 17'($urandom);
        @(posedge clk); #1;
        checkOutput("reset1", zeroE());

        // Release while PCSrcE had been high: no bubble carries over.
        reset     = 1'b1;
        PCSrcE    = 1'b0;
        RegWriteW = 1'b0;
        applyStimulus("nop", 17'h1F000, 0, 0, 4'd0, 32'd0);

        // Same-cycle write of r3 and R-type read of r3 on both ports.
        applyStimulus("r3rw", {5'b00000, 4'd1, 4'd3, 4'd3}, 0, 1, 4'd3, 32'h1234);
        checkVal("r3_rd1", 64'(RD1E), 64'h1234);
        checkVal("r3_rd2", 64'(RD2E), 64'h1234);

        applyStimulus("ialu", 17'h0823F, 0, 0, 4'd0, 32'd0);
        checkVal("ialu_imm", 64'(ImmExtE), 64'hFFFF_FFFF);
        applyStimulus("jal", 17'h1C480, 0, 0, 4'd0, 32'd0);
        checkVal("jal_imm", 64'(ImmExtE), 64'hFFFF_FF80);

        // r0 ignores writes.
        applyStimulus("r0w", 17'h1F000, 0, 1, 4'd0, 32'hDEAD);
        applyStimulus("r0r", 17'h00100, 0, 0, 4'd0, 32'd0);
        checkVal("r0_rd1", 64'(RD1E), 64'd0);

        // One-cycle flush: two bubbles, then the next instruction decodes.
        applyStimulus("fl1a", 17'h01234, 1, 0, 4'd0, 32'd0);
        applyStimulus("fl1b", 17'h02345, 0, 0, 4'd0, 32'd0);
        applyStimulus("fl1c", 17'h03456, 0, 0, 4'd0, 32'd0);
        checkVal("fl1_pce", 64'(PCE), 64'(pcCnt - 12'd1));

        // Two-cycle flush: three bubbles.
        applyStimulus("fl2a", 17'h04567, 1, 0, 4'd0, 32'd0);
        applyStimulus("fl2b", 17'h05678, 1, 0, 4'd0, 32'd0);
        applyStimulus("fl2c", 17'h06789, 0, 0, 4'd0, 32'd0);
        applyStimulus("fl2d", 17'h0789A, 0, 0, 4'd0, 32'd0);

        // Load into r5 followed by a consumer of r5 as rs2.
        applyStimulus("ld5", {5'b10000, 4'd5, 4'd1, 4'd0}, 0, 0, 4'd0, 32'd0);
        applyStimulus("use5", {5'b00000, 4'd2, 4'd1, 4'd5}, 0, 0, 4'd0, 32'd0);
        applyStimulus("use5b", {5'b00000, 4'd2, 4'd1, 4'd5}, 0, 0, 4'd0, 32'd0);
        applyStimulus("ld5f", {5'b10000, 4'd5, 4'd1, 4'd0}, 0, 0, 4'd0, 32'd0);
        applyStimulus("use5f", {5'b00000, 4'd2, 4'd1, 4'd5}, 1, 0, 4'd0, 32'd0);
        applyStimulus("use5g", {5'b00000, 4'd2, 4'd1, 4'd5}, 0, 0, 4'd0, 32'd0);

        // Randomized stream with writebacks and occasional flushes.
        for (int n = 0; n < 300; n++) begin
            applyStimulus("rand", 17'($urandom), ($urandom_range(0, 11) == 0),
                          bit'($urandom_range(0, 1)), 4'($urandom), $urandom);
        end

        // Asynchronous reset mid-run clears E outputs and the register file.
        #2;
        reset = 1'b0;
        #1;
        checkOutput("areset", zeroE());
        for (int i = 0; i < 16; i++) regsModel[i] = 32'd0;
        curE      = zeroE();
        flushPrev = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        applyStimulus("post", {5'b00000, 4'd1, 4'd3, 4'd4}, 0, 0, 4'd0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
